// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: counter width, full-duty code,
// default prescale, and the per-pin output mode decode.
package pwm_pkg;

   localparam int unsigned PWM_CNT_W        = 8;
   localparam int unsigned N_OUT            = 16;
   localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
   localparam int unsigned PRESCALE_DEFAULT = 13;

   typedef enum logic [1:0] {
      PIN_OFF,    // output forced low
      PIN_ON,     // output forced high
      PIN_PWM     // output follows the shared PWM level
   } pin_mode_e;

   // The PWM-mode bit only matters when the output itself is enabled.
   function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
      if (!en_out)
         return PIN_OFF;
      else if (!en_pwm)
         return PIN_ON;
      else
         return PIN_PWM;
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler for the PWM counter.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high for one clk every PRESCALE clks (every clk when PRESCALE=1)
module pwm_tick_gen
   import pwm_pkg::*;
#(
   parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_cnt;

   assign tick = (pre_cnt == PRE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pre_cnt <= '0;
      else if (tick)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + 1'b1;
   end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output PWM peripheral with a single shared duty cycle.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   en_reg_out_15_8/7_0 : per-pin output enables
//   en_reg_pwm_15_8/7_0 : per-pin PWM-mode selects (ignored while disabled)
//   pwm_duty_cycle      : duty in 1/256 steps, 0xFF = always high;
//                         sampled only at the period boundary
//   out_15_8/out_7_0    : registered pin outputs
//   period_start        : one-clk pulse in the first clk of each period
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] en_reg_out_7_0,
   input  logic [7:0] en_reg_out_15_8,
   input  logic [7:0] en_reg_pwm_7_0,
   input  logic [7:0] en_reg_pwm_15_8,
   input  logic [7:0] pwm_duty_cycle,
   output logic [7:0] out_7_0,
   output logic [7:0] out_15_8,
   output logic       period_start
);

   logic                 tick;
   logic                 wrap;
   logic                 pwm_level;
   logic [PWM_CNT_W-1:0] pwm_cnt;
   logic [PWM_CNT_W-1:0] duty_shadow;
   logic [N_OUT-1:0]     en_out;
   logic [N_OUT-1:0]     en_pwm;
   logic [N_OUT-1:0]     out_next;

   pwm_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   // The tick that takes pwm_cnt from 255 back to 0.
   assign wrap = tick && (pwm_cnt == '1);

   always_comb begin
      pwm_level = (duty_shadow == DUTY_FULL) || (pwm_cnt < duty_shadow);
      out_next  = '0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         case (pin_mode(en_out[i], en_pwm[i]))
            PIN_ON:  out_next[i] = 1'b1;
            PIN_PWM: out_next[i] = pwm_level;
            default: out_next[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt      <= '0;
         duty_shadow  <= '0;
         period_start <= 1'b0;
         out_7_0      <= '0;
         out_15_8     <= '0;
      end else begin
         period_start <= wrap;
         if (tick)
            pwm_cnt <= pwm_cnt + 1'b1;
         if (wrap)
            duty_shadow <= pwm_duty_cycle;
         {out_15_8, out_7_0} <= out_next;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral at PRESCALE=13.
module tb_pwm_peripheral;

   localparam int P   = 13;
   localparam int PER = 256 * P;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] en_out = '0;
   logic [15:0] en_pwm = '0;
   logic [7:0]  duty = '0;
   logic [7:0]  out_7_0, out_15_8;
   logic        period_start;
   logic [15:0] out16;

   assign out16 = {out_15_8, out_7_0};

   always #5 clk = ~clk;

   pwm_peripheral #(
      .PRESCALE (P)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_out[7:0]),
      .en_reg_out_15_8 (en_out[15:8]),
      .en_reg_pwm_7_0  (en_pwm[7:0]),
      .en_reg_pwm_15_8 (en_pwm[15:8]),
      .pwm_duty_cycle  (duty),
      .out_7_0         (out_7_0),
      .out_15_8        (out_15_8),
      .period_start    (period_start)
   );

   typedef struct {
      string       name;
      logic [15:0] out;
      logic        ps;
   } snap_t;

   typedef struct {
      string             name;
      int                len;
      int                first_low;
      logic [15:0][12:0] hi;
   } per_t;

   snap_t snap_q[$];
   per_t  per_q[$];
   int    lat_q[$];
   event  snap_ev;

   int n_pass  = 0;
   int n_total = 0;

   // Cycles since reset release and period_start pulses seen since then.
   int cyc  = 0;
   int n_ps = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc  <= 0;
         n_ps <= 0;
      end else begin
         cyc <= cyc + 1;
         if (period_start)
            n_ps <= n_ps + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   function automatic int exp_hi(input bit eo, input bit ep, input int d);
      if (!eo)                return 0;
      if (!ep || d == 255)    return PER;
      return d * P;
   endfunction

   task automatic push_snap(input string name, input logic [15:0] o, input logic ps);
      snap_t s;
      s.name = name;
      s.out  = o;
      s.ps   = ps;
      snap_q.push_back(s);
      ->snap_ev;
   endtask

   task automatic push_per(input string name, input logic [15:0] eo, input logic [15:0] ep, input int d);
      per_t r;
      r.name      = name;
      r.len       = PER;
      r.first_low = exp_hi(eo[0], ep[0], d);
      for (int i = 0; i < 16; i++)
         r.hi[i] = 13'(exp_hi(eo[i], ep[i], d));
      per_q.push_back(r);
   endtask

   task automatic wait_ps(input string name);
      bit seen = 0;
      for (int i = 0; i < PER + 600 && !seen; i++) begin
         @(negedge clk);
         if (period_start) seen = 1;
      end
      if (!seen) begin
         n_total++;
         $display("FAIL wait_%s: got no period_start required within %0d clk", name, PER + 600);
      end
   endtask

   // Snapshot monitor: compares the outputs at the instant a snapshot is requested.
   initial begin
      snap_t s;
      forever begin
         @(snap_ev);
         while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            check(s.name, int'(out16), int'(s.out));
            check({s.name, "_ps"}, int'(period_start), int'(s.ps));
         end
      end
   end

   // Period monitor: an output period runs from the clk after one
   // period_start to the clk after the next (outputs lag pwm_cnt by 1 clk).
   initial begin
      per_t r;
      int   win_len = 0;
      int   win_first_low = -1;
      int   win_hi[16];
      bit   open = 0;
      bit   ps_prev = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            open    = 0;
            ps_prev = 0;
            per_q.delete();
         end else begin
            if (ps_prev) begin
               if (open && per_q.size() > 0) begin
                  r = per_q.pop_front();
                  check({r.name, "_len"}, win_len, r.len);
                  check({r.name, "_first_low"}, (win_first_low < 0) ? win_len : win_first_low, r.first_low);
                  for (int i = 0; i < 16; i++)
                     check($sformatf("%s_hi[%0d]", r.name, i), win_hi[i], int'(r.hi[i]));
               end
               open          = 1;
               win_len       = 0;
               win_first_low = -1;
               for (int i = 0; i < 16; i++) win_hi[i] = 0;
            end
            if (open) begin
               if (win_first_low < 0 && !out16[0]) win_first_low = win_len;
               for (int i = 0; i < 16; i++)
                  if (out16[i]) win_hi[i]++;
               win_len++;
            end
            if (period_start && n_ps == 0 && lat_q.size() > 0)
               check("first_period_start_clk", cyc, lat_q.pop_front());
            ps_prev = period_start;
         end
      end
   end

   initial begin
      #(PER * 10 * 20);
      n_total++;
      $display("FAIL watchdog: got timeout at %0t required completion", $time);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Stimulus
   initial begin
      repeat (3) @(negedge clk);
      push_snap("reset", 16'h0000, 1'b0);
      lat_q.push_back(PER);
      rst_n = 1'b1;

      @(negedge clk);
      en_out = 16'h00FF;
      en_pwm = 16'h0000;
      duty   = 8'h80;
      push_snap("static_pre_edge", 16'h0000, 1'b0);
      @(posedge clk); #1;
      push_snap("static", 16'h00FF, 1'b0);

      @(negedge clk);
      en_out = 16'hFFFF;
      en_pwm = 16'hFFFF;
      @(posedge clk); #1;
      push_snap("pwm_before_first_wrap", 16'h0000, 1'b0);

      wait_ps("p0"); push_per("duty80", 16'hFFFF, 16'hFFFF, 8'h80); duty = 8'h00;
      wait_ps("p1"); push_per("duty00", 16'hFFFF, 16'hFFFF, 8'h00); duty = 8'hFF;
      wait_ps("p2"); push_per("dutyFF", 16'hFFFF, 16'hFFFF, 8'hFF); duty = 8'h01;
      wait_ps("p3"); push_per("duty01", 16'hFFFF, 16'hFFFF, 8'h01); duty = 8'h40;
      wait_ps("p4"); push_per("mid_old40", 16'hFFFF, 16'hFFFF, 8'h40);
      repeat (8'h20 * P) @(negedge clk);
      duty = 8'hC0;
      wait_ps("p5"); push_per("mid_newC0", 16'hFFFF, 16'hFFFF, 8'hC0); duty = 8'h40;
      wait_ps("p6"); push_per("mixed", 16'hA5A5, 16'h0F0F, 8'h40);
      en_out = 16'hA5A5;
      en_pwm = 16'h0F0F;
      repeat (100) @(negedge clk);
      push_snap("mixed_high", 16'hA5A5, 1'b0);
      repeat (8'h40 * P) @(negedge clk);
      push_snap("mixed_low", 16'hA0A0, 1'b0);

      wait_ps("p7");
      repeat (200) @(negedge clk);
      push_snap("mixed_high_pre_reset", 16'hA5A5, 1'b0);
      rst_n = 1'b0;
      #1;
      push_snap("async_reset", 16'h0000, 1'b0);
      repeat (3) @(negedge clk);
      lat_q.push_back(PER);
      rst_n = 1'b1;
      @(posedge clk); #1;
      push_snap("after_release", 16'hA0A0, 1'b0);

      wait_ps("p_after_reset");
      repeat (2) @(negedge clk);
      check("lat_q_drained", lat_q.size(), 0);
      check("per_q_drained", per_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
